eth_cmd_arbiter: RTL and testbench

//  Shares the single KSZ8851 register-access engine (offset/length/WR/writeData/NewCommand, state/readData) among
//  NUM_REQ requesters: port 0 = init sequencer, then RX poller, TX loader, IRQ handler. Sits between them and the engine.

---
 rtl/eth_cmd_pkg.sv | 28 ++
 rtl/eth_cmd_arbiter_rr_pick.sv | 27 ++
 rtl/eth_cmd_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_eth_cmd_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_cmd_pkg.sv
// Shared constants for the KSZ8851 command arbiter:
// engine state codes, arbiter FSM states, timeout error word.
package eth_cmd_pkg;

  localparam logic [3:0] ENG_ADDR0  = 4'd0;
  localparam logic [3:0] ENG_READ1  = 4'd4;
  localparam logic [3:0] ENG_READ2  = 4'd5;
  localparam logic [3:0] ENG_WRITE1 = 4'd7;
  localparam logic [3:0] ENG_WRITE2 = 4'd8;
  localparam logic [3:0] ENG_WAIT   = 4'd9;

  localparam logic [15:0] ARB_ERR_WORD = 16'hDEAD;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BUSY
  } arb_state_e;

  function automatic logic eng_phase1(input logic [3:0] s);
    return (s == ENG_READ1) || (s == ENG_WRITE1);
  endfunction

  function automatic logic eng_phase2(input logic [3:0] s);
    return (s == ENG_READ2) || (s == ENG_WRITE2);
  endfunction

endpackage

// File: rtl/eth_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible
// requester at or after ptr, wrapping to 0.
module eth_cmd_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [PW-1:0]      pick_idx
);

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (pick_oh == '0 && eligible[idx]) begin
        pick_oh[idx] = 1'b1;
        pick_idx     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/eth_cmd_arbiter.sv
// Round-robin arbiter sharing the KSZ8851 register engine.
// Optional watchdog: define ARB_TIMEOUT_EN.
module eth_cmd_arbiter
  import eth_cmd_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk40m,
  input  logic                    reset,
  input  logic                    init_done,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [NUM_REQ-1:0]      req_len,
  input  logic [8*NUM_REQ-1:0]    req_offset,
  input  logic [16*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      err,
  output logic [15:0]             rd_data,
  output logic [7:0]              offset,
  output logic                    length,
  output logic                    WR,
  output logic [15:0]             writeData,
  output logic                    NewCommand,
  input  logic [3:0]              state,
  input  logic [15:0]             readData
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_e st_q, st_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      own_q, own_d;
  logic [15:0]        rd_q, rd_d;
  logic [7:0]         off_q, off_d;
  logic               len_q, len_d;
  logic               wr_q, wr_d;
  logic [15:0]        wd_q, wd_d;
  logic               nc_q, nc_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      pick_idx;

  function automatic logic [PW-1:0] ptr_next(
    input logic [PW-1:0] p
  );
    return (p == PW'(NUM_REQ-1)) ? '0 : p + 1'b1;
  endfunction

  assign eligible = req & (init_done ? {NUM_REQ{1'b1}}
                                     : NUM_REQ'(1));

  eth_cmd_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) < 12)
                    ? 12 : $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`endif

  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    done_d = '0;
    ptr_d  = ptr_q;
    own_d  = own_q;
    rd_d   = rd_q;
    off_d  = off_q;
    len_d  = len_q;
    wr_d   = wr_q;
    wd_d   = wd_q;
    nc_d   = nc_q;
`ifdef ARB_TIMEOUT_EN
    err_d  = '0;
    cnt_d  = cnt_q + 1'b1;
`endif
    unique case (st_q)
      ARB_IDLE: begin
        // skip the done cycle so the owner can drop req
        if (pick_oh != '0 && state == ENG_WAIT
            && done_q == '0) begin
          gnt_d = pick_oh;
          own_d = pick_idx;
          off_d = req_offset[8*pick_idx +: 8];
          len_d = req_len[pick_idx];
          wr_d  = req_wr[pick_idx];
          wd_d  = req_wr[pick_idx]
                ? req_wdata[16*pick_idx +: 16] : 16'h0000;
          nc_d  = 1'b1;
          st_d  = ARB_ISSUE;
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ARB_ISSUE: begin
        if (eng_phase1(state)) begin
          nc_d = 1'b0;
          st_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (eng_phase2(state)) begin
          rd_d   = readData;
          done_d = gnt_q;
          gnt_d  = '0;
          st_d   = ARB_IDLE;
          ptr_d  = req_lock[own_q] ? own_q : ptr_next(own_q);
        end
      end
      default: st_d = ARB_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    if (st_q != ARB_IDLE && cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
      nc_d   = 1'b0;
      done_d = gnt_q;
      err_d  = gnt_q;
      rd_d   = ARB_ERR_WORD;
      gnt_d  = '0;
      st_d   = ARB_IDLE;
      ptr_d  = ptr_next(own_q);
    end
`endif
  end

  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      st_q   <= ARB_IDLE;
      gnt_q  <= '0;
      done_q <= '0;
      ptr_q  <= PW'(1);
      own_q  <= '0;
      rd_q   <= '0;
      off_q  <= '0;
      len_q  <= 1'b0;
      wr_q   <= 1'b0;
      wd_q   <= '0;
      nc_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q  <= '0;
      err_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      ptr_q  <= ptr_d;
      own_q  <= own_d;
      rd_q   <= rd_d;
      off_q  <= off_d;
      len_q  <= len_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
      nc_q   <= nc_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q  <= cnt_d;
      err_q  <= err_d;
`endif
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = '0;
`endif

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign rd_data    = rd_q;
  assign offset     = off_q;
  assign length     = len_q;
  assign WR         = wr_q;
  assign writeData  = wd_q;
  assign NewCommand = nc_q;

endmodule

// File: tb/tb_eth_cmd_arbiter.sv
// Testbench for eth_cmd_arbiter: engine model, requester
// driver, scoreboard monitor with round-robin reference.
module tb_eth_cmd_arbiter;
  import eth_cmd_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;

  logic            clk40m = 1'b0;
  logic            reset  = 1'b0;
  logic            init_done = 1'b0;
  logic [N-1:0]    req = '0, req_lock = '0;
  logic [N-1:0]    req_wr = '0, req_len = '0;
  logic [8*N-1:0]  req_offset = '0;
  logic [16*N-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, done, err;
  logic [15:0]     rd_data, writeData, readData;
  logic [7:0]      offset;
  logic            length, WR, NewCommand;
  logic [3:0]      state;

  always #5 clk40m = ~clk40m;

  eth_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk40m(clk40m), .reset(reset), .init_done(init_done),
    .req(req), .req_lock(req_lock), .req_wr(req_wr),
    .req_len(req_len), .req_offset(req_offset),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
    .rd_data(rd_data), .offset(offset), .length(length),
    .WR(WR), .writeData(writeData), .NewCommand(NewCommand),
    .state(state), .readData(readData)
  );

  typedef struct {
    int idx; bit wr; bit len; logic [7:0] off;
    logic [15:0] wd; bit lock; bit to;
  } cmd_t;
  typedef struct { int idx; logic [15:0] data; bit to; } exp_t;

  cmd_t cmdq[$];
  exp_t expq[$];
  int   order[$];
  logic [15:0] ref_mem [256];
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, nc_cyc = 0;
  int pres_cyc [N];
  bit lazy = 0;
  int max_dly = 0;

  function automatic logic [15:0] init_val(input int a);
    if (a == 'hC0) return 16'h8872;
    return 16'(a * 257) ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk40m) cyc <= cyc + 1;

  // engine model
  logic [3:0]  eng_st = ENG_WAIT;
  logic [7:0]  eng_off = '0;
  logic        eng_wr = 1'b0;
  logic [15:0] eng_wd = '0;
  logic [15:0] eng_mem [256];
  int          eng_dly = 0;
  int          stuck = 0;
  bit          eng_rst = 1'b1, mem_ok = 1'b0;

  assign state    = eng_st;
  assign readData = eng_mem[eng_off];

  always @(posedge clk40m) begin
    if (eng_rst) begin
      eng_st <= ENG_WAIT;
      if (!mem_ok) begin
        for (int a = 0; a < 256; a++) eng_mem[a] <= init_val(a);
        mem_ok <= 1'b1;
      end
    end else begin
      case (eng_st)
        ENG_WAIT: if (NewCommand) begin
          eng_st  <= ENG_ADDR0;
          eng_off <= offset;
          eng_wr  <= WR;
          eng_wd  <= writeData;
          eng_dly <= $urandom_range(0, max_dly);
        end
        ENG_ADDR0: if (stuck != 1) begin
          if (eng_dly == 0) eng_st <= eng_wr ? ENG_WRITE1 : ENG_READ1;
          else eng_dly <= eng_dly - 1;
        end
        ENG_READ1:  if (stuck != 2) eng_st <= ENG_READ2;
        ENG_WRITE1: if (stuck != 2) eng_st <= ENG_WRITE2;
        ENG_READ2:  eng_st <= ENG_WAIT;
        ENG_WRITE2: begin
          eng_mem[eng_off] <= eng_wd;
          eng_st <= ENG_WAIT;
        end
        default: eng_st <= ENG_WAIT;
      endcase
    end
  end

  // monitor: rr reference and completion scoreboard
  logic [N-1:0]    req_p, lock_p, wr_p, len_p;
  logic [8*N-1:0]  off_p;
  logic [16*N-1:0] wd_p;
  logic            init_p, nc_p;
  int ptr_m = 1, owner_m = -1;
  bit lock_m = 0;

  always @(negedge clk40m) begin
    if (!reset) begin
      ptr_m = 1; owner_m = -1; nc_p = 1'b0;
    end else begin
      chk("err_alone", 32'(err & ~done), 0);
      if (done != '0) begin
        int g, j;
        g = -1; j = -1;
        for (int k = N-1; k >= 0; k--) if (done[k]) g = k;
        chk("done_owner", 32'(done),
            owner_m >= 0 ? 32'(1 << owner_m) : 0);
        for (int k = expq.size()-1; k >= 0; k--)
          if (expq[k].idx == g) j = k;
        if (j < 0) chk("sb_missing", 32'(g), 32'hFFFF_FFFF);
        else begin
          chk("rd_data", 32'(rd_data),
              expq[j].to ? 32'(ARB_ERR_WORD) : 32'(expq[j].data));
          chk("err", 32'(err), expq[j].to ? 32'(done) : 0);
          if (expq[j].to) chk("timeout_lat", 32'(cyc - nc_cyc), TO);
          expq.delete(j);
        end
        ptr_m = (err != '0 || !lock_m) ? (g + 1) % N : g;
        done_cnt++;
        owner_m = -1;
      end
      if (NewCommand && !nc_p) begin
        logic [N-1:0] pend;
        int win;
        pend = req_p & (init_p ? {N{1'b1}} : N'(1));
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && pend[(ptr_m + k) % N]) win = (ptr_m + k) % N;
        if (win < 0) chk("spurious_grant", 32'(gnt), 0);
        else begin
          chk("gnt", 32'(gnt), 32'(1 << win));
          chk("offset", 32'(offset), 32'(off_p[8*win +: 8]));
          chk("wr", 32'(WR), 32'(wr_p[win]));
          chk("length", 32'(length), 32'(len_p[win]));
          chk("writeData", 32'(writeData),
              wr_p[win] ? 32'(wd_p[16*win +: 16]) : 0);
          owner_m = win;
          lock_m  = lock_p[win];
          nc_cyc  = cyc;
          order.push_back(win);
        end
      end
      nc_p = NewCommand;
    end
    req_p = req; lock_p = req_lock; wr_p = req_wr; len_p = req_len;
    off_p = req_offset; wd_p = req_wdata; init_p = init_done;
  end

  // requester driver, one step per clock just after the edge
  task automatic drive_step();
    for (int i = 0; i < N; i++)
      if (done[i]) begin req[i] = 1'b0; req_lock[i] = 1'b0; end
    for (int i = 0; i < N; i++) begin
      int j;
      j = -1;
      for (int k = cmdq.size()-1; k >= 0; k--)
        if (cmdq[k].idx == i) j = k;
      if (!req[i] && j >= 0 && (!lazy || $urandom_range(0, 1) == 1)) begin
        exp_t e;
        cmd_t c;
        c = cmdq[j];
        cmdq.delete(j);
        req_wr[i] = c.wr; req_len[i] = c.len; req_lock[i] = c.lock;
        req_offset[8*i +: 8] = c.off;
        req_wdata[16*i +: 16] = c.wd;
        req[i] = 1'b1;
        e.idx = i; e.data = ref_mem[c.off]; e.to = c.to;
        if (c.wr && !c.to) ref_mem[c.off] = c.wd;
        expq.push_back(e);
        pres_cyc[i] = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin @(posedge clk40m); #1; drive_step(); end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k;
    k = 0;
    while ((cmdq.size() != 0 || expq.size() != 0 || req != '0)
           && k < budget) begin
      run(1); k++;
    end
    chk(nm, 32'(k < budget), 1);
  endtask

  task automatic push(input int i, input bit wr, input logic [7:0] off,
                      input bit lock, input bit to);
    cmd_t c;
    c.idx = i; c.wr = wr; c.len = 1'($urandom); c.off = off;
    c.wd = 16'($urandom); c.lock = lock; c.to = to;
    cmdq.push_back(c);
  endtask

  task automatic flush_and_reset();
    reset = 1'b0;
    cmdq.delete(); expq.delete();
    req = '0; req_lock = '0; stuck = 0; eng_rst = 1'b1;
    run(2);
    eng_rst = 1'b0;
  endtask

  task automatic do_reset();
    flush_and_reset();
    reset = 1'b1;
    run(1);
  endtask

  initial begin
    int o0, d0;
    int exp3 [6];
    bit to5;
    exp3 = '{1, 2, 3, 1, 2, 3};
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
    run(3);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_offset", 32'(offset), 0);
    chk("rst_len_wr", 32'({length, WR}), 0);
    chk("rst_writeData", 32'(writeData), 0);
    chk("rst_nc", 32'(NewCommand), 0);
    eng_rst = 1'b0; reset = 1'b1;
    run(1);

    // single read during init
    push(0, 1'b0, 8'hC0, 1'b0, 1'b0);
    wait_drain("t1_drain", 50);
    chk("t1_latency", 32'(nc_cyc - pres_cyc[0]), 1);
    chk("t1_rd_data", 32'(rd_data), 32'h8872);

    // init gating
    do_reset();
    init_done = 1'b0;
    o0 = order.size();
    push(1, 1'b0, 8'h45, 1'b0, 1'b0);
    run(1000);
    chk("t2_gated", 32'(order.size() - o0), 0);
    init_done = 1'b1;
    run(2);
    chk("t2_gnt", 32'(gnt), 32'b0010);
    wait_drain("t2_drain", 50);

    // round robin
    do_reset();
    o0 = order.size();
    for (int k = 0; k < 6; k++)
      push(exp3[k], 1'($urandom),
           8'(exp3[k] * 64 + $urandom_range(0, 63)), 1'b0, 1'b0);
    wait_drain("t3_drain", 200);
    chk("t3_count", 32'(order.size() - o0), 6);
    for (int k = 0; k < 6; k++)
      chk("t3_order", 32'(order[o0 + k]), 32'(exp3[k]));

    // locked read-modify-write
    do_reset();
    o0 = order.size();
    push(2, 1'b0, 8'hF6, 1'b1, 1'b0);
    push(2, 1'b1, 8'hF6, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !NewCommand; k++) run(1);
    push(1, 1'b0, 8'h50, 1'b0, 1'b0);
    wait_drain("t4_drain", 200);
    chk("t4_first", 32'(order[o0]), 2);
    chk("t4_second", 32'(order[o0 + 1]), 2);
    chk("t4_third", 32'(order[o0 + 2]), 1);

    // engine stuck in Addr0
    do_reset();
`ifdef ARB_TIMEOUT_EN
    to5 = 1'b1;
`else
    to5 = 1'b0;
`endif
    stuck = 1;
    d0 = done_cnt;
    push(3, 1'b0, 8'hD0, 1'b0, to5);
    if (to5) begin
      wait_drain("t5_timeout", 200);
      stuck = 0; eng_rst = 1'b1;
      run(2);
      eng_rst = 1'b0;
      push(0, 1'b0, 8'h20, 1'b0, 1'b0);
      wait_drain("t5_next", 50);
      chk("t5_next_owner", 32'(order[order.size() - 1]), 0);
    end else begin
      run(200);
      chk("t5_hang_done", 32'(done_cnt - d0), 0);
      chk("t5_hang_gnt", 32'(gnt), 32'b1000);
      chk("t5_hang_nc", 32'(NewCommand), 1);
    end

    // reset while busy
    do_reset();
    stuck = 2;
    push(3, 1'b0, 8'hD1, 1'b0, 1'b0);
    run(10);
    chk("t6_busy_gnt", 32'(gnt), 32'b1000);
    chk("t6_busy_state", 32'(state), 32'(ENG_READ1));
    reset = 1'b0;
    #2;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_nc", 32'(NewCommand), 0);
    chk("t6_outs", 32'({done, err, length, WR}), 0);
    chk("t6_data", 32'({offset, writeData}), 0);
    chk("t6_rd", 32'(rd_data), 0);
    flush_and_reset();
    push(0, 1'b0, 8'h21, 1'b0, 1'b0);
    push(2, 1'b0, 8'h91, 1'b0, 1'b0);
    run(1);
    reset = 1'b1;
    run(1);
    chk("t6_regrant", 32'(gnt), 32'b0100);
    wait_drain("t6_drain", 100);

    // randomized traffic
    do_reset();
    lazy = 1; max_dly = 3;
    d0 = done_cnt;
    for (int k = 0; k < 80; k++) begin
      int i;
      i = $urandom_range(0, N-1);
      push(i, 1'($urandom), 8'(i * 64 + $urandom_range(0, 63)),
           $urandom_range(0, 3) == 0, 1'b0);
    end
    wait_drain("rand_drain", 20000);
    chk("rand_count", 32'(done_cnt - d0), 80);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
